// File: rtl/uart_rx_deframer.sv
// uart_rx_deframer: console UART receive deframer.
// Samples the raw rx pin through a 2-flop synchroniser, checks each frame,
// buffers good bytes in a FIFO and offers them as a valid/ready stream.
// Parity, framing and overrun errors are reported as sticky flags.
// Build option: define UART_RX_PARITY_EN for 8E1 framing (even parity bit
// checked). Leave it undefined for 8N1 framing (no parity bit, io_parity_err
// tied low).
module uart_rx_deframer #(
    parameter int CLKS_PER_BIT = 6,
    parameter int FIFO_DEPTH   = 16
) (
    input  logic                        io_clk,
    input  logic                        io_nreset,
    input  logic                        io_rx,
    output logic                        io_data_valid,
    input  logic                        io_data_ready,
    output logic [7:0]                  io_data_payload,
    output logic [$clog2(FIFO_DEPTH):0] io_fifo_level,
    output logic                        io_parity_err,
    output logic                        io_frame_err,
    output logic                        io_overrun,
    input  logic                        io_err_clear
);
    localparam int TW = $clog2(CLKS_PER_BIT);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int PW = AW + 1;
    localparam logic [TW-1:0] TICK_HALF = TW'(CLKS_PER_BIT / 2 - 1);
    localparam logic [TW-1:0] TICK_FULL = TW'(CLKS_PER_BIT - 1);
    localparam logic [TW-1:0] TICK_ONE  = TW'(1);
    localparam logic [PW-1:0] PTR_ONE   = PW'(1);

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_START  = 3'd1,
        ST_DATA   = 3'd2,
`ifdef UART_RX_PARITY_EN
        ST_PARITY = 3'd3,
`endif
        ST_STOP   = 3'd4,
        ST_BREAK  = 3'd5
    } state_t;

`ifdef UART_RX_PARITY_EN
    // Even parity over the data byte: the parity bit must equal this value.
    function automatic logic even_parity_f(input logic [7:0] data);
        return ^data;
    endfunction
`endif

    logic [1:0]    sync_r;
    logic          rxs_s;
    logic [1:0]    settle_r;
    logic          rx_prev_r;
    state_t        state_r;
    logic [TW-1:0] tick_r;
    logic [2:0]    bit_cnt_r;
    logic [7:0]    shift_r;
    logic          par_bad_s;
    logic          sample_s;
    logic          start_s;
    logic          stop_sample_s;
    logic          push_s;
    logic          frame_set_s;
    logic          parity_set_s;
    logic          overrun_set_s;
    logic          push_ok_s;
    logic          pop_s;
    logic          full_s;
    logic [7:0]    mem_r [FIFO_DEPTH];
    logic [PW-1:0] wr_ptr_r;
    logic [PW-1:0] rd_ptr_r;
    logic          parity_err_r;
    logic          frame_err_r;
    logic          overrun_r;

    assign rxs_s = sync_r[1];

    // Two-flop synchroniser for the asynchronous rx pin; resets to idle-high.
    always_ff @(posedge io_clk or negedge io_nreset) begin
        if (!io_nreset) begin
            sync_r <= 2'b11;
        end else begin
            sync_r <= {sync_r[0], io_rx};
        end
    end

    // Start-edge history; held low until the synchroniser reflects the real
    // pin so a line already low at reset release never looks like a 1->0 edge.
    always_ff @(posedge io_clk or negedge io_nreset) begin
        if (!io_nreset) begin
            settle_r  <= 2'd0;
            rx_prev_r <= 1'b0;
        end else begin
            if (settle_r != 2'd2) begin
                settle_r <= settle_r + 2'd1;
            end else begin
                settle_r <= settle_r;
            end
            rx_prev_r <= (settle_r == 2'd2) ? rxs_s : 1'b0;
        end
    end

    // Per-frame decisions taken at the current sample point.
    always_comb begin
        sample_s      = (tick_r == {TW{1'b0}});
        start_s       = rx_prev_r & ~rxs_s;
        stop_sample_s = (state_r == ST_STOP) && sample_s;
        frame_set_s   = stop_sample_s && !rxs_s;
        parity_set_s  = stop_sample_s && rxs_s && par_bad_s;
        push_s        = stop_sample_s && rxs_s && !par_bad_s;
        pop_s         = io_data_valid && io_data_ready;
        full_s        = (wr_ptr_r[AW] != rd_ptr_r[AW]) &&
                        (wr_ptr_r[AW-1:0] == rd_ptr_r[AW-1:0]);
        push_ok_s     = push_s && (!full_s || pop_s);
        overrun_set_s = push_s && full_s && !pop_s;
    end

`ifdef UART_RX_PARITY_EN
    logic par_bad_r;
    assign par_bad_s = par_bad_r;
`else
    assign par_bad_s = 1'b0;
`endif

    // Frame FSM: half-bit wait to the start-bit centre, then one sample per bit.
    always_ff @(posedge io_clk or negedge io_nreset) begin
        if (!io_nreset) begin
            state_r   <= ST_IDLE;
            tick_r    <= {TW{1'b0}};
            bit_cnt_r <= 3'd0;
            shift_r   <= 8'h00;
`ifdef UART_RX_PARITY_EN
            par_bad_r <= 1'b0;
`endif
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (start_s) begin
                        state_r <= ST_START;
                        tick_r  <= TICK_HALF;
                    end else begin
                        state_r <= ST_IDLE;
                    end
                end
                ST_START: begin
                    if (!sample_s) begin
                        tick_r <= tick_r - TICK_ONE;
                    end else if (rxs_s) begin
                        state_r <= ST_IDLE;
                    end else begin
                        state_r   <= ST_DATA;
                        tick_r    <= TICK_FULL;
                        bit_cnt_r <= 3'd0;
`ifdef UART_RX_PARITY_EN
                        par_bad_r <= 1'b0;
`endif
                    end
                end
                ST_DATA: begin
                    if (sample_s) begin
                        shift_r   <= {rxs_s, shift_r[7:1]};
                        tick_r    <= TICK_FULL;
                        bit_cnt_r <= bit_cnt_r + 3'd1;
                        if (bit_cnt_r == 3'd7) begin
`ifdef UART_RX_PARITY_EN
                            state_r <= ST_PARITY;
`else
                            state_r <= ST_STOP;
`endif
                        end else begin
                            state_r <= ST_DATA;
                        end
                    end else begin
                        tick_r <= tick_r - TICK_ONE;
                    end
                end
`ifdef UART_RX_PARITY_EN
                ST_PARITY: begin
                    if (sample_s) begin
                        par_bad_r <= (rxs_s != even_parity_f(shift_r));
                        tick_r    <= TICK_FULL;
                        state_r   <= ST_STOP;
                    end else begin
                        tick_r <= tick_r - TICK_ONE;
                    end
                end
`endif
                ST_STOP: begin
                    if (sample_s) begin
                        state_r <= rxs_s ? ST_IDLE : ST_BREAK;
                    end else begin
                        tick_r <= tick_r - TICK_ONE;
                    end
                end
                ST_BREAK: begin
                    if (rxs_s) begin
                        state_r <= ST_IDLE;
                    end else begin
                        state_r <= ST_BREAK;
                    end
                end
                default: begin
                    state_r <= ST_IDLE;
                end
            endcase
        end
    end

    // Receive FIFO storage and pointers; a full FIFO still accepts a push
    // when the head is popped in the same cycle.
    always_ff @(posedge io_clk or negedge io_nreset) begin
        if (!io_nreset) begin
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                mem_r[i] <= 8'h00;
            end
            wr_ptr_r <= {PW{1'b0}};
            rd_ptr_r <= {PW{1'b0}};
        end else begin
            if (push_ok_s) begin
                mem_r[wr_ptr_r[AW-1:0]] <= shift_r;
                wr_ptr_r                <= wr_ptr_r + PTR_ONE;
            end else begin
                wr_ptr_r <= wr_ptr_r;
            end
            if (pop_s) begin
                rd_ptr_r <= rd_ptr_r + PTR_ONE;
            end else begin
                rd_ptr_r <= rd_ptr_r;
            end
        end
    end

    // Sticky error flags; a new error wins over a simultaneous clear.
    always_ff @(posedge io_clk or negedge io_nreset) begin
        if (!io_nreset) begin
            parity_err_r <= 1'b0;
            frame_err_r  <= 1'b0;
            overrun_r    <= 1'b0;
        end else begin
            parity_err_r <= parity_set_s  ? 1'b1 : (io_err_clear ? 1'b0 : parity_err_r);
            frame_err_r  <= frame_set_s   ? 1'b1 : (io_err_clear ? 1'b0 : frame_err_r);
            overrun_r    <= overrun_set_s ? 1'b1 : (io_err_clear ? 1'b0 : overrun_r);
        end
    end

    assign io_data_valid   = (wr_ptr_r != rd_ptr_r);
    assign io_data_payload = mem_r[rd_ptr_r[AW-1:0]];
    assign io_fifo_level   = wr_ptr_r - rd_ptr_r;
    assign io_frame_err    = frame_err_r;
    assign io_overrun      = overrun_r;
`ifdef UART_RX_PARITY_EN
    assign io_parity_err   = parity_err_r;
`else
    assign io_parity_err   = 1'b0;
`endif

endmodule

// File: tb/tb_uart_rx_deframer.sv
// tb_uart_rx_deframer: self-checking bench for uart_rx_deframer.
// A frame-level model predicts delivered bytes and sticky flags from the
// bits sent on the line; popped bytes are collected by a negedge monitor.
module tb_uart_rx_deframer;
    localparam int CPB   = 6;
    localparam int DEPTH = 16;
`ifdef UART_RX_PARITY_EN
    localparam bit PAR = 1'b1;
`else
    localparam bit PAR = 1'b0;
`endif

    logic       io_clk        = 1'b0;
    logic       io_nreset     = 1'b0;
    logic       io_rx         = 1'b1;
    logic       io_data_ready = 1'b0;
    logic       io_err_clear  = 1'b0;
    logic       io_data_valid;
    logic [7:0] io_data_payload;
    logic [4:0] io_fifo_level;
    logic       io_parity_err;
    logic       io_frame_err;
    logic       io_overrun;

    int         checks   = 0;
    int         failures = 0;
    logic [7:0] got_q[$];
    logic [7:0] exp_q[$];
    logic       exp_par = 1'b0;
    logic       exp_frm = 1'b0;
    logic       exp_ovr = 1'b0;

    uart_rx_deframer #(.CLKS_PER_BIT(CPB), .FIFO_DEPTH(DEPTH)) dut (
        .io_clk          (io_clk),
        .io_nreset       (io_nreset),
        .io_rx           (io_rx),
        .io_data_valid   (io_data_valid),
        .io_data_ready   (io_data_ready),
        .io_data_payload (io_data_payload),
        .io_fifo_level   (io_fifo_level),
        .io_parity_err   (io_parity_err),
        .io_frame_err    (io_frame_err),
        .io_overrun      (io_overrun),
        .io_err_clear    (io_err_clear)
    );

    always #5 io_clk = ~io_clk;

    // Collect every accepted stream beat, sampled away from the rising edge.
    always @(negedge io_clk) begin
        if (io_nreset && io_data_valid && io_data_ready) got_q.push_back(io_data_payload);
    end

    task automatic tick(input int n);
        repeat (n) @(posedge io_clk);
        #2;
    endtask

    task automatic drive_bit(input logic b);
        io_rx = b;
        tick(CPB);
    endtask

    task automatic idle(input int nbits);
        io_rx = 1'b1;
        tick(nbits * CPB);
    endtask

    // One frame on the line: start, 8 data LSB first, optional parity, stop.
    task automatic send_frame(input logic [7:0] d, input logic par_good, input logic stop_bit);
        logic p;
        p = par_good ? (^d) : ~(^d);
        drive_bit(1'b0);
        for (int i = 0; i < 8; i++) drive_bit(d[i]);
        if (PAR) drive_bit(p);
        drive_bit(stop_bit);
    endtask

    // Frame-level expectation: frame error beats parity error beats delivery.
    task automatic model_frame(input logic [7:0] d, input logic par_good, input logic stop_bit);
        if (!stop_bit) exp_frm = 1'b1;
        else if (PAR && !par_good) exp_par = 1'b1;
        else exp_q.push_back(d);
    endtask

    task automatic pulse_clear();
        io_err_clear = 1'b1;
        tick(1);
        io_err_clear = 1'b0;
        tick(1);
        exp_par = 1'b0;
        exp_frm = 1'b0;
        exp_ovr = 1'b0;
    endtask

    task automatic test_reset();
        io_nreset = 1'b0;
        tick(3);
        checks++; if (io_data_valid !== 1'b0) begin failures++; $display("FAIL reset_valid actual=%b expected=0", io_data_valid); end
        checks++; if (io_data_payload !== 8'h00) begin failures++; $display("FAIL reset_payload actual=%h expected=00", io_data_payload); end
        checks++; if (io_fifo_level !== 5'd0) begin failures++; $display("FAIL reset_level actual=%0d expected=0", io_fifo_level); end
        checks++; if (io_parity_err !== 1'b0) begin failures++; $display("FAIL reset_parity actual=%b expected=0", io_parity_err); end
        checks++; if (io_frame_err !== 1'b0) begin failures++; $display("FAIL reset_frame actual=%b expected=0", io_frame_err); end
        checks++; if (io_overrun !== 1'b0) begin failures++; $display("FAIL reset_overrun actual=%b expected=0", io_overrun); end
        io_nreset = 1'b1;
        idle(4);
        checks++; if (io_data_valid !== 1'b0) begin failures++; $display("FAIL reset_release_valid actual=%b expected=0", io_data_valid); end
    endtask

    task automatic test_good_byte();
        pulse_clear();
        io_data_ready = 1'b1;
        send_frame(8'hA5, 1'b1, 1'b1); model_frame(8'hA5, 1'b1, 1'b1);
        idle(2);
        checks++;
        if (got_q.size() != exp_q.size()) begin failures++; $display("FAIL good_byte_count actual=%0d expected=%0d", got_q.size(), exp_q.size()); end
        else for (int i = 0; i < exp_q.size(); i++) begin
            checks++; if (got_q[i] !== exp_q[i]) begin failures++; $display("FAIL good_byte_data[%0d] actual=%h expected=%h", i, got_q[i], exp_q[i]); end
        end
        checks++; if (io_parity_err !== exp_par) begin failures++; $display("FAIL good_byte_parity actual=%b expected=%b", io_parity_err, exp_par); end
        checks++; if (io_frame_err !== exp_frm) begin failures++; $display("FAIL good_byte_frame actual=%b expected=%b", io_frame_err, exp_frm); end
        checks++; if (io_overrun !== exp_ovr) begin failures++; $display("FAIL good_byte_overrun actual=%b expected=%b", io_overrun, exp_ovr); end
        got_q.delete(); exp_q.delete();
    endtask

    task automatic test_parity();
        pulse_clear();
        io_data_ready = 1'b1;
        send_frame(8'h3C, 1'b0, 1'b1); model_frame(8'h3C, 1'b0, 1'b1);
        idle(2);
        checks++; if (io_parity_err !== exp_par) begin failures++; $display("FAIL parity_flag actual=%b expected=%b", io_parity_err, exp_par); end
        checks++; if (io_frame_err !== exp_frm) begin failures++; $display("FAIL parity_frame actual=%b expected=%b", io_frame_err, exp_frm); end
        send_frame(8'h3D, 1'b1, 1'b1); model_frame(8'h3D, 1'b1, 1'b1);
        idle(2);
        checks++;
        if (got_q.size() != exp_q.size()) begin failures++; $display("FAIL parity_count actual=%0d expected=%0d", got_q.size(), exp_q.size()); end
        else for (int i = 0; i < exp_q.size(); i++) begin
            checks++; if (got_q[i] !== exp_q[i]) begin failures++; $display("FAIL parity_data[%0d] actual=%h expected=%h", i, got_q[i], exp_q[i]); end
        end
        got_q.delete(); exp_q.delete();
    endtask

    task automatic test_frame_error();
        pulse_clear();
        io_data_ready = 1'b1;
        send_frame(8'h12, 1'b1, 1'b0); model_frame(8'h12, 1'b1, 1'b0);
        drive_bit(1'b0);
        idle(2);
        send_frame(8'h55, 1'b1, 1'b1); model_frame(8'h55, 1'b1, 1'b1);
        idle(2);
        checks++; if (io_frame_err !== exp_frm) begin failures++; $display("FAIL frame_flag actual=%b expected=%b", io_frame_err, exp_frm); end
        checks++; if (io_parity_err !== exp_par) begin failures++; $display("FAIL frame_parity actual=%b expected=%b", io_parity_err, exp_par); end
        checks++;
        if (got_q.size() != exp_q.size()) begin failures++; $display("FAIL frame_count actual=%0d expected=%0d", got_q.size(), exp_q.size()); end
        else for (int i = 0; i < exp_q.size(); i++) begin
            checks++; if (got_q[i] !== exp_q[i]) begin failures++; $display("FAIL frame_data[%0d] actual=%h expected=%h", i, got_q[i], exp_q[i]); end
        end
        got_q.delete(); exp_q.delete();
    endtask

    task automatic test_back_to_back_overrun();
        int exp_level;
        pulse_clear();
        io_data_ready = 1'b0;
        for (int i = 0; i <= DEPTH; i++) begin
            send_frame(8'(i), 1'b1, 1'b1);
            if (exp_q.size() < DEPTH) exp_q.push_back(8'(i));
            else exp_ovr = 1'b1;
        end
        idle(2);
        exp_level = exp_q.size();
        checks++; if (io_fifo_level !== 5'(exp_level)) begin failures++; $display("FAIL overrun_level actual=%0d expected=%0d", io_fifo_level, exp_level); end
        checks++; if (io_overrun !== exp_ovr) begin failures++; $display("FAIL overrun_flag actual=%b expected=%b", io_overrun, exp_ovr); end
        checks++; if (io_data_valid !== 1'b1) begin failures++; $display("FAIL overrun_valid actual=%b expected=1", io_data_valid); end
        checks++; if (io_data_payload !== exp_q[0]) begin failures++; $display("FAIL overrun_head actual=%h expected=%h", io_data_payload, exp_q[0]); end
        io_data_ready = 1'b1;
        tick(DEPTH + 4);
        checks++;
        if (got_q.size() != exp_q.size()) begin failures++; $display("FAIL drain_count actual=%0d expected=%0d", got_q.size(), exp_q.size()); end
        else for (int i = 0; i < exp_q.size(); i++) begin
            checks++; if (got_q[i] !== exp_q[i]) begin failures++; $display("FAIL drain_data[%0d] actual=%h expected=%h", i, got_q[i], exp_q[i]); end
        end
        got_q.delete(); exp_q.delete();
        pulse_clear();
        checks++; if (io_overrun !== exp_ovr) begin failures++; $display("FAIL clear_overrun actual=%b expected=%b", io_overrun, exp_ovr); end
        checks++; if (io_frame_err !== exp_frm) begin failures++; $display("FAIL clear_frame actual=%b expected=%b", io_frame_err, exp_frm); end
        checks++; if (io_parity_err !== exp_par) begin failures++; $display("FAIL clear_parity actual=%b expected=%b", io_parity_err, exp_par); end
        checks++; if (io_fifo_level !== 5'd0) begin failures++; $display("FAIL drain_level actual=%0d expected=0", io_fifo_level); end
    endtask

    task automatic test_false_start();
        logic [7:0] d;
        pulse_clear();
        io_data_ready = 1'b1;
        io_rx = 1'b0;
        tick(2);
        idle(3);
        checks++; if (got_q.size() != 0) begin failures++; $display("FAIL glitch_beats actual=%0d expected=0", got_q.size()); end
        checks++; if (io_frame_err !== exp_frm) begin failures++; $display("FAIL glitch_frame actual=%b expected=%b", io_frame_err, exp_frm); end
        checks++; if (io_parity_err !== exp_par) begin failures++; $display("FAIL glitch_parity actual=%b expected=%b", io_parity_err, exp_par); end
        d = 8'($urandom);
        send_frame(d, 1'b1, 1'b1); model_frame(d, 1'b1, 1'b1);
        idle(2);
        checks++;
        if (got_q.size() != exp_q.size()) begin failures++; $display("FAIL glitch_next_count actual=%0d expected=%0d", got_q.size(), exp_q.size()); end
        else for (int i = 0; i < exp_q.size(); i++) begin
            checks++; if (got_q[i] !== exp_q[i]) begin failures++; $display("FAIL glitch_next_data actual=%h expected=%h", got_q[i], exp_q[i]); end
        end
        got_q.delete(); exp_q.delete();
    endtask

    task automatic test_random();
        logic [7:0] d;
        logic       pg;
        logic       sb;
        pulse_clear();
        for (int n = 0; n < 12; n++) begin
            d  = 8'($urandom);
            pg = ($urandom_range(0, 4) != 0);
            sb = ($urandom_range(0, 5) != 0);
            io_data_ready = 1'($urandom_range(0, 1));
            send_frame(d, pg, sb); model_frame(d, pg, sb);
            if (sb) idle($urandom_range(0, 2));
            else idle(1 + $urandom_range(0, 1));
        end
        io_data_ready = 1'b1;
        idle(2);
        tick(DEPTH + 4);
        checks++;
        if (got_q.size() != exp_q.size()) begin failures++; $display("FAIL random_count actual=%0d expected=%0d", got_q.size(), exp_q.size()); end
        else for (int i = 0; i < exp_q.size(); i++) begin
            checks++; if (got_q[i] !== exp_q[i]) begin failures++; $display("FAIL random_data[%0d] actual=%h expected=%h", i, got_q[i], exp_q[i]); end
        end
        checks++; if (io_parity_err !== exp_par) begin failures++; $display("FAIL random_parity actual=%b expected=%b", io_parity_err, exp_par); end
        checks++; if (io_frame_err !== exp_frm) begin failures++; $display("FAIL random_frame actual=%b expected=%b", io_frame_err, exp_frm); end
        checks++; if (io_overrun !== exp_ovr) begin failures++; $display("FAIL random_overrun actual=%b expected=%b", io_overrun, exp_ovr); end
        got_q.delete(); exp_q.delete();
    endtask

    task automatic test_reset_midframe();
        io_data_ready = 1'b1;
        drive_bit(1'b0);
        for (int i = 0; i < 4; i++) drive_bit(1'b1);
        io_nreset = 1'b0;
        #1;
        checks++; if (io_data_valid !== 1'b0) begin failures++; $display("FAIL midreset_valid actual=%b expected=0", io_data_valid); end
        checks++; if (io_fifo_level !== 5'd0) begin failures++; $display("FAIL midreset_level actual=%0d expected=0", io_fifo_level); end
        checks++; if (io_frame_err !== 1'b0) begin failures++; $display("FAIL midreset_frame actual=%b expected=0", io_frame_err); end
        io_rx = 1'b1;
        tick(2);
        io_nreset = 1'b1;
        got_q.delete(); exp_q.delete();
        exp_par = 1'b0; exp_frm = 1'b0; exp_ovr = 1'b0;
        idle(2);
        send_frame(8'h81, 1'b1, 1'b1); model_frame(8'h81, 1'b1, 1'b1);
        idle(2);
        checks++;
        if (got_q.size() != exp_q.size()) begin failures++; $display("FAIL midreset_count actual=%0d expected=%0d", got_q.size(), exp_q.size()); end
        else for (int i = 0; i < exp_q.size(); i++) begin
            checks++; if (got_q[i] !== exp_q[i]) begin failures++; $display("FAIL midreset_data actual=%h expected=%h", got_q[i], exp_q[i]); end
        end
        checks++; if (io_frame_err !== exp_frm) begin failures++; $display("FAIL midreset_frame_after actual=%b expected=%b", io_frame_err, exp_frm); end
        checks++; if (io_parity_err !== exp_par) begin failures++; $display("FAIL midreset_parity_after actual=%b expected=%b", io_parity_err, exp_par); end
        got_q.delete(); exp_q.delete();
    endtask

    initial begin
        test_reset();
        test_good_byte();
        test_parity();
        test_frame_error();
        test_back_to_back_overrun();
        test_false_start();
        test_random();
        test_reset_midframe();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
